// File: rtl/int_mult_pkg.sv
// Shared FSM state and mode encodings for the sequential integer multiplier.
package int_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // bit 0 = signed operands, bit 1 = return upper half
  localparam logic [1:0] MODE_ULO = 2'd0;
  localparam logic [1:0] MODE_SLO = 2'd1;
  localparam logic [1:0] MODE_UHI = 2'd2;
  localparam logic [1:0] MODE_SHI = 2'd3;

endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add step over a {upper, multiplier} accumulator.
module shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;

  // carry out of the upper add lands in the MSB after the shift
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, mcand_i} : '0);
    acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/int_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier: unsigned/signed, low/high half select.
module int_mult_seq
  import int_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  // Magnitudes of the most-negative value stay correct as unsigned WIDTH bits.
  always_comb begin
    mag_a = (n[0] && dataa[WIDTH-1]) ? (~dataa + 1'b1) : dataa;
    mag_b = (n[0] && datab[WIDTH-1]) ? (~datab + 1'b1) : datab;
    prod  = (mode_q[0] && sign_q) ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = mag_a;
        acc_d   = {{WIDTH{1'b0}}, mag_b};
        cnt_d   = CNT_W'(WIDTH);
        mode_d  = n;
        sign_d  = n[0] & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
      end
      BUSY: begin
        if (cnt_q != '0) begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = mode_q[1] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mode_q   <= MODE_ULO;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_int_mult_seq.sv
// Directed + random checks of int_mult_seq against an arithmetic product model.
module tb_int_mult_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clk_en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dataa = '0;
  logic [W-1:0] datab = '0;
  logic [1:0]   n = '0;
  logic [W-1:0] result;
  logic         done;

  int tests = 0;
  int fails = 0;

  int_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] p;
    sa = $signed({{W{a[W-1]}}, a});
    sb = $signed({{W{b[W-1]}}, b});
    if (m[0]) p = sa * sb;
    else      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return m[1] ? p[2*W-1:W] : p[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // e counts edges after the accept edge; done must first appear after edge W+1+stall_len
  // (cycle W+2 when the start-sampling cycle is cycle 0).
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input int stall_at, input int stall_len,
                        input int extra_start, input int done_stall, input bit start_at_exit);
    int e, got, dcnt;
    logic [W-1:0] exp;
    exp = ref_mul(a, b, m);
    @(negedge clk);
    clk_en = 1'b1; start = 1'b1; dataa = a; datab = b; n = m;
    @(negedge clk);
    start = 1'b0; dataa = $urandom; datab = $urandom; n = 2'($urandom);
    e = 0; got = -1;
    while (e < 200) begin
      if (done) begin got = e; break; end
      clk_en = !(stall_len > 0 && e >= stall_at && e < stall_at + stall_len);
      start  = (e == extra_start);
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(got), 64'(W + 1 + stall_len));
    chk({tag, " result"}, 64'(result), 64'(exp));
    if (done_stall > 0) begin
      dcnt = 0;
      clk_en = 1'b0;
      for (int i = 0; i < done_stall; i++) begin
        @(negedge clk);
        if (done && result === exp) dcnt++;
      end
      chk({tag, " done held in stall"}, 64'(dcnt), 64'(done_stall));
      clk_en = 1'b1;
    end
    start = start_at_exit;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk({tag, " single pulse"}, 64'(dcnt), 64'd0);
    chk({tag, " result hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;
    logic [1:0]   rm;
    #1;
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("1x2 ulo",      32'd1,          32'd2,          2'd0, 0, 0, -1, 0, 1'b0);
    run_op("-6x-6 slo",    32'hFFFFFFFA,   32'hFFFFFFFA,   2'd1, 0, 0, -1, 0, 1'b0);
    run_op("-6x-6 uhi",    32'hFFFFFFFA,   32'hFFFFFFFA,   2'd2, 0, 0, -1, 0, 1'b0);
    run_op("-6x-6 shi",    32'hFFFFFFFA,   32'hFFFFFFFA,   2'd3, 0, 0, -1, 0, 1'b0);
    run_op("-6x2 shi",     32'hFFFFFFFA,   32'd2,          2'd3, 0, 0, -1, 0, 1'b0);
    run_op("-6x2 slo",     32'hFFFFFFFA,   32'd2,          2'd1, 0, 0, -1, 0, 1'b0);
    run_op("minxmin shi",  32'h80000000,   32'h80000000,   2'd3, 0, 0, -1, 0, 1'b0);
    run_op("2x23 stall",   32'd2,          32'd23,         2'd0, 12, 5, 20, 0, 1'b0);
    run_op("zero op",      32'd0,          32'hDEADBEEF,   2'd2, 0, 0, -1, 3, 1'b1);
    run_op("min x 3 slo",  32'h80000000,   32'd3,          2'd1, 0, 0, 5, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ra = $urandom; rb = $urandom; rm = 2'($urandom);
      run_op($sformatf("rand%0d", k), ra, rb, rm,
             int'($urandom_range(1, 25)), int'($urandom_range(0, 4)), -1, 0, 1'b0);
    end

    // reset in the middle of an operation
    @(negedge clk);
    clk_en = 1'b1; start = 1'b1; dataa = 32'd1234; datab = 32'd5678; n = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("no done after abort", 64'(cnt), 64'd0);
    run_op("3x4 after reset", 32'd3, 32'd4, 2'd0, 0, 0, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/int_mult_seq.md
INT_MULT_SEQ -- requirements
Module: int_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_en  input  1  global stall; low freezes all state, outputs hold.
REQ-006 SHALL have port start  input  1  launch request, sampled in IDLE only.
REQ-007 SHALL have port dataa  input  WIDTH  multiplicand, captured on accepted start.
REQ-008 SHALL have port datab  input  WIDTH  multiplier, captured on accepted start.
REQ-009 SHALL have port n  input  2  mode, captured on accepted start: 0 unsigned-low, 1 signed-low, 2 unsigned-high, 3 signed-high.
REQ-010 SHALL have port result  output  WIDTH  selected half of 2*WIDTH product.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; any state advances only when clk_en=1.
REQ-013 IDLE: start=1 & clk_en=1 -> capture operands/mode, load counter WIDTH, go BUSY.
REQ-014 Signed modes: capture magnitudes |dataa|, |datab|; record sign = dataa[MSB] XOR datab[MSB].
REQ-015 BUSY: one radix-2 shift-add step per enabled cycle (conditional add of multiplicand to upper accumulator, shift right 1, counter-1); counter reaches 0 -> DONE.
REQ-016 Entering DONE SHALL apply two's-complement negation to 2*WIDTH product if signed and sign=1, then register selected half into result.
REQ-017 DONE: done=1 for exactly one enabled cycle, then IDLE.
REQ-018 Latency: with clk_en held high, done SHALL be high in cycle WIDTH+2 counted from start-accept edge as cycle 0 (WIDTH BUSY cycles, 1 finalize cycle).
REQ-019 clk_en=0 in any state SHALL extend latency by exactly the stalled cycles; done held, not re-pulsed, across stall.
REQ-020 start while BUSY or DONE SHALL be ignored; no queueing.
REQ-021 start in IDLE coincident with DONE exit edge SHALL be ignored (start only accepted while state==IDLE).
REQ-022 result SHALL hold last value from DONE until next DONE; dataa/datab/n changes after accept SHALL not affect result.
REQ-023 Most-negative operand (1<<WIDTH-1) in signed modes SHALL produce correct product (magnitude held unsigned WIDTH bits).
REQ-024 Zero operand SHALL still take full latency.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, done=0, result=0, counter=0, accumulator=0, irrespective of clk_en.
REQ-026 Reset mid-BUSY SHALL abort operation; no done pulse for aborted operation after reset release.
REQ-027 First start accepted on first enabled edge with reset_n=1.

Structure
REQ-028 Shared package int_mult_pkg SHALL hold FSM state enum and mode encodings (MODE_ULO, MODE_SLO, MODE_UHI, MODE_SHI).
REQ-029 Datapath step (conditional add + shift) SHALL be one sub-module, shift_add_step, combinational, parametrised by WIDTH; FSM/counter/sign handling stay in int_mult_seq.
REQ-030 No vendor multiplier IP or `*` operator in datapath.

Verification (WIDTH=32, clk_en=1 unless stated)
REQ-031 dataa=1, datab=2, n=0 -> done in cycle 34, result=0x00000002.
REQ-032 dataa=datab=0xFFFFFFFA: n=1 -> 0x00000024; n=2 -> 0xFFFFFFF4; n=3 -> 0x00000000.
REQ-033 dataa=0xFFFFFFFA, datab=2, n=3 -> 0xFFFFFFFF; n=1 -> 0xFFFFFFF4; dataa=0x80000000, datab=0x80000000, n=3 -> 0x40000000.
REQ-034 dataa=2, datab=23, n=0, clk_en low 5 cycles mid-BUSY -> done in cycle 39, result=0x0000002E; second start pulse during BUSY ignored (single done).
REQ-035 reset_n low 1 cycle at cycle 10 of BUSY -> result=0, done=0 immediately, no later done; next start (3*4, n=0) -> 0x0000000C.
